// File: rtl/if_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : if_prefetch_unit
//  Brief    : Instruction-fetch stage with a DEPTH-entry prefetch queue.
//             Owns the PC, issues single-outstanding req/ack fetches, buffers
//             {instruction, PC+step} pairs for IF/ID and resolves redirects,
//             dropping stale fetches and flushing the queue.
//  Revision : 1.0 - initial release
// ============================================================================
module if_prefetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h00010000,
  parameter int              PC_STEP  = 4
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            fromPCSRC,
  input  logic [1:0]      fromJUMP,
  input  logic [1:0]      fromRJUMP,
  input  logic [XLEN-1:0] BRANCHGO,
  input  logic [XLEN-1:0] fromJJAL,
  input  logic [XLEN-1:0] fromJRJALR,
  input  logic            STALL,
  output logic [XLEN-1:0] IADRESS,
  output logic            IREQ,
  input  logic            IACK,
  input  logic [XLEN-1:0] OUTDATA,
  output logic [XLEN-1:0] MAINORDER,
  output logic [XLEN-1:0] goifidpc4,
  output logic            ORDERVALID,
  output logic            FLASHIF
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [XLEN-1:0] C_STEP  = XLEN'(PC_STEP);
  localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_FETCH   = 1'b0,
    ST_DISCARD = 1'b1
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_target;
  logic            r_req;

  logic [XLEN-1:0] r_q_instr [DEPTH];
  logic [XLEN-1:0] r_q_pc4   [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;

  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic            w_xfer;
  logic            w_valid;
  logic            w_push;
  logic            w_pop;
  logic [AW:0]     w_count_next;

  // Redirect decode with jr/jalr > j/jal > branch priority, plus queue control
  always_comb begin
    w_redirect = fromPCSRC | (|fromJUMP) | (|fromRJUMP);
    if (|fromRJUMP)
      w_target = fromJRJALR;
    else if (|fromJUMP)
      w_target = fromJJAL;
    else
      w_target = BRANCHGO;
    w_xfer       = r_req & IACK;
    w_valid      = (r_count != '0);
    // Words arriving in DISCARD are stale; a redirect discards everything
    w_push       = (r_state == ST_FETCH) & w_xfer & ~w_redirect;
    w_pop        = w_valid & ~STALL & ~w_redirect;
    w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  end

  // Fetch FSM: PC ownership, request issue and stale-fetch discard
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= ST_FETCH;
      r_fetch_pc <= RESET_PC;
      r_target   <= '0;
      r_req      <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_redirect) begin
            if (r_req && !IACK) begin
              // Request cannot be withdrawn: wait for it, then jump
              r_target <= w_target;
              r_state  <= ST_DISCARD;
            end else begin
              // Queue is flushed, so there is always room for a new request
              r_fetch_pc <= w_target;
              r_req      <= 1'b1;
            end
          end else begin
            if (w_xfer)
              r_fetch_pc <= r_fetch_pc + C_STEP;
            r_req <= (r_req && !IACK) || (w_count_next < C_DEPTH);
          end
        end
        ST_DISCARD: begin
          if (IACK) begin
            r_fetch_pc <= w_redirect ? w_target : r_target;
            r_state    <= ST_FETCH;
            r_req      <= 1'b1;
          end else if (w_redirect) begin
            r_target <= w_target;
          end
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_redirect) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_next;
    end
  end

  // Queue storage; contents are only observed through a valid head
  always_ff @(posedge CLOCK) begin
    if (w_push) begin
      r_q_instr[r_wptr] <= OUTDATA;
      r_q_pc4[r_wptr]   <= r_fetch_pc + C_STEP;
    end
  end

  assign IADRESS    = r_fetch_pc;
  assign IREQ       = r_req;
  assign ORDERVALID = w_valid;
  assign MAINORDER  = w_valid ? r_q_instr[r_rptr] : '0;
  assign goifidpc4  = w_valid ? r_q_pc4[r_rptr]   : '0;
  assign FLASHIF    = w_redirect;

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_prefetch_unit
//  Brief    : Scoreboard bench for if_prefetch_unit. Directed stimulus pushes
//             the expected IF/ID words; a negedge monitor pops and compares
//             every word the ID stage consumes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_unit;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        fromPCSRC;
  logic [1:0]  fromJUMP;
  logic [1:0]  fromRJUMP;
  logic [31:0] BRANCHGO;
  logic [31:0] fromJJAL;
  logic [31:0] fromJRJALR;
  logic        STALL;
  logic [31:0] IADRESS;
  logic        IREQ;
  logic        IACK;
  logic [31:0] OUTDATA;
  logic [31:0] MAINORDER;
  logic [31:0] goifidpc4;
  logic        ORDERVALID;
  logic        FLASHIF;
  logic        ack_en;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } item_t;
  item_t sb[$];

  if_prefetch_unit dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .fromPCSRC(fromPCSRC), .fromJUMP(fromJUMP), .fromRJUMP(fromRJUMP),
    .BRANCHGO(BRANCHGO), .fromJJAL(fromJJAL), .fromJRJALR(fromJRJALR),
    .STALL(STALL), .IADRESS(IADRESS), .IREQ(IREQ), .IACK(IACK),
    .OUTDATA(OUTDATA), .MAINORDER(MAINORDER), .goifidpc4(goifidpc4),
    .ORDERVALID(ORDERVALID), .FLASHIF(FLASHIF)
  );

  always #5 CLOCK = ~CLOCK;

  // Order memory: word content is a fixed scramble of its address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign IACK    = ack_en;
  assign OUTDATA = mem_word(IADRESS);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = base + 32'(4 * i);
      sb.push_back({mem_word(a), a + 32'd4});
    end
  endtask

  task automatic wait_full();
    repeat (6) step();
    chk("idle_ireq_low", {31'd0, IREQ}, 32'd0);
  endtask

  task automatic consume3();
    STALL = 1'b0;
    repeat (4) step();
    STALL = 1'b1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every head consumed by ID must match the next expected word
  always @(negedge CLOCK) begin
    if (RESET === 1'b1 && ORDERVALID === 1'b1 && STALL === 1'b0 && FLASHIF === 1'b0) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: actual instr=%h pc4=%h required none", MAINORDER, goifidpc4);
      end else begin
        item_t e;
        e = sb.pop_front();
        if ({MAINORDER, goifidpc4} !== e) begin
          n_bad++;
          $display("FAIL sb_item: actual instr=%h pc4=%h required instr=%h pc4=%h",
                   MAINORDER, goifidpc4, e.instr, e.pc4);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b0; fromPCSRC = 1'b0; fromJUMP = 2'b00; fromRJUMP = 2'b00;
    BRANCHGO = '0; fromJJAL = '0; fromJRJALR = '0; STALL = 1'b0; ack_en = 1'b1;
    repeat (3) step();
    chk("rst_ireq", {31'd0, IREQ}, 32'd0);
    chk("rst_valid", {31'd0, ORDERVALID}, 32'd0);
    chk("rst_mainorder", MAINORDER, 32'd0);
    chk("rst_pc4", goifidpc4, 32'd0);

    // 1: free-running sequential fetch
    push_seq(32'h0001_0000, 4);
    RESET = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("seq_iadress", IADRESS, 32'h0001_0000 + 32'(4 * (k - 1)));
      chk("seq_ireq", {31'd0, IREQ}, 32'd1);
      if (k == 1) chk("seq_first_valid", {31'd0, ORDERVALID}, 32'd0);
    end

    // 2: stall fills the queue, then drain in order
    STALL = 1'b1;
    repeat (9) step();
    chk("stall_ireq_low", {31'd0, IREQ}, 32'd0);
    chk("stall_valid", {31'd0, ORDERVALID}, 32'd1);
    chk("stall_head", MAINORDER, mem_word(32'h0001_0010));
    chk("stall_head_pc4", goifidpc4, 32'h0001_0014);
    step();
    push_seq(32'h0001_0010, 8);
    STALL = 1'b0;
    repeat (8) step();
    STALL = 1'b1;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // 3: branch with no request pending
    wait_full();
    fromPCSRC = 1'b1; BRANCHGO = 32'h0002_0000;
    #1;
    chk("br_flashif", {31'd0, FLASHIF}, 32'd1);
    step();
    fromPCSRC = 1'b0;
    #1;
    chk("br_flashif_clr", {31'd0, FLASHIF}, 32'd0);
    chk("br_valid_low", {31'd0, ORDERVALID}, 32'd0);
    chk("br_iadress", IADRESS, 32'h0002_0000);
    chk("br_ireq", {31'd0, IREQ}, 32'd1);
    push_seq(32'h0002_0000, 3);
    consume3();

    // 4: jump while a request is pending without ack
    wait_full();
    ack_en = 1'b0;
    fromPCSRC = 1'b1; BRANCHGO = 32'h0001_0008;
    step();
    fromPCSRC = 1'b0;
    fromJUMP = 2'b01; fromJJAL = 32'h0003_0000;
    #1;
    chk("pend_ireq", {31'd0, IREQ}, 32'd1);
    chk("pend_iadress", IADRESS, 32'h0001_0008);
    chk("pend_flashif", {31'd0, FLASHIF}, 32'd1);
    step();
    fromJUMP = 2'b00;
    chk("disc_iadress_hold", IADRESS, 32'h0001_0008);
    chk("disc_ireq_hold", {31'd0, IREQ}, 32'd1);
    chk("disc_valid_low", {31'd0, ORDERVALID}, 32'd0);
    step();
    chk("disc_iadress_hold2", IADRESS, 32'h0001_0008);
    ack_en = 1'b1;
    step();
    chk("jmp_iadress", IADRESS, 32'h0003_0000);
    chk("jmp_ireq", {31'd0, IREQ}, 32'd1);
    chk("jmp_valid_low", {31'd0, ORDERVALID}, 32'd0);
    push_seq(32'h0003_0000, 3);
    consume3();

    // 5: simultaneous branch, jump and register jump
    wait_full();
    fromPCSRC = 1'b1; fromRJUMP = 2'b01; fromJUMP = 2'b10;
    BRANCHGO = 32'h0002_0000; fromJRJALR = 32'h0004_0000; fromJJAL = 32'h0003_0000;
    step();
    fromPCSRC = 1'b0; fromRJUMP = 2'b00; fromJUMP = 2'b00;
    chk("prio_iadress", IADRESS, 32'h0004_0000);
    push_seq(32'h0004_0000, 3);
    consume3();

    // 6: address wrap, then reset during a pending request
    wait_full();
    fromJUMP = 2'b11; fromJJAL = 32'hFFFF_FFFC;
    step();
    fromJUMP = 2'b00;
    chk("wrap_iadress0", IADRESS, 32'hFFFF_FFFC);
    push_seq(32'hFFFF_FFFC, 3);
    STALL = 1'b0;
    step();
    chk("wrap_iadress1", IADRESS, 32'h0000_0000);
    repeat (3) step();
    STALL = 1'b1;
    ack_en = 1'b0;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    repeat (2) step();
    chk("pre_rst_ireq", {31'd0, IREQ}, 32'd1);
    chk("pre_rst_valid", {31'd0, ORDERVALID}, 32'd1);
    RESET = 1'b0;
    #1;
    chk("mid_rst_ireq", {31'd0, IREQ}, 32'd0);
    chk("mid_rst_valid", {31'd0, ORDERVALID}, 32'd0);
    chk("mid_rst_mainorder", MAINORDER, 32'd0);
    step();
    RESET = 1'b1;
    ack_en = 1'b1;
    step();
    chk("refetch_iadress", IADRESS, 32'h0001_0000);
    chk("refetch_ireq", {31'd0, IREQ}, 32'd1);
    chk("refetch_valid_low", {31'd0, ORDERVALID}, 32'd0);
    push_seq(32'h0001_0000, 3);
    consume3();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
